// File: rtl/fire_expand1_ofm_writer_if.sv
// Feature-map RAM write bus shared by all lanes.
// The writer drives it as master; the banked RAM is the slave.
interface fire_expand1_ofm_writer_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 8,
    parameter int AW    = 14
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data [0:LANES-1];

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/fire_expand1_ofm_writer.sv
// Expand-1x1 output writer: captures CHOUT words per pixel and
// drains them LANES at a time into a channel-group-major banked RAM.
module fire_expand1_ofm_writer #(
    parameter int WOUT  = 32,
    parameter int CHOUT = 128,
    parameter int WIDTH = 16,
    parameter int LANES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          layer_en,
    input  logic                          sample,
    input  logic [WIDTH-1:0]              ofm [0:CHOUT-1],
    fire_expand1_ofm_writer_if.master     wr,
    output logic                          busy,
    output logic                          ram_feedback,
    output logic                          overrun,
    output logic [$clog2(WOUT*WOUT):0]    pixel_count
);
    localparam int GROUPS = CHOUT / LANES;
    localparam int NPIX   = WOUT * WOUT;
    localparam int AW     = $clog2(GROUPS * NPIX);
    localparam int PCW    = $clog2(NPIX) + 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int CW     = (CHOUT > 1) ? $clog2(CHOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shadow   [0:CHOUT-1];
    logic [WIDTH-1:0] nxt_lane [0:LANES-1];
    logic [GW-1:0]    group;
    logic [GW-1:0]    ng;
    logic [PCW-1:0]   pc_inc;
    logic [PCW-1:0]   pc_tgt;
    logic             last;
    logic             capture;
    logic             advance;
    logic             finish_px;

    assign busy         = (state == DRAIN);
    assign ram_feedback = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next state plus the per-edge capture/advance/finish decisions
    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        advance   = 1'b0;
        finish_px = 1'b0;
        last      = (group == GW'(GROUPS - 1));
        pc_inc    = pixel_count + PCW'(1);
        unique case (state)
            IDLE: begin
                if (layer_en && sample) begin
                    state_n = DRAIN;
                    capture = 1'b1;
                end
            end
            DRAIN: begin
                if (!layer_en) begin
                    state_n = IDLE;
                end else if (!last) begin
                    advance = 1'b1;
                end else begin
                    finish_px = 1'b1;
                    if (pc_inc == PCW'(NPIX)) state_n = DONE;
                    else if (sample)          capture = 1'b1;
                    else                      state_n = IDLE;
                end
            end
            DONE: begin
                if (!layer_en) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        pc_tgt = finish_px ? pc_inc : pixel_count;
    end

    // Lane words of the next group, taken from the shadow copy
    always_comb begin
        ng = group + GW'(1);
        for (int l = 0; l < LANES; l++) begin
            nxt_lane[l] = shadow[CW'(ng) * CW'(LANES) + CW'(l)];
        end
    end

    // Shadow, counters, sticky overrun and the registered write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < CHOUT; c++) shadow[c] <= '0;
            for (int l = 0; l < LANES; l++) wr.wr_data[l] <= '0;
            group       <= '0;
            pixel_count <= '0;
            overrun     <= 1'b0;
            wr.wr_en    <= 1'b0;
            wr.wr_addr  <= '0;
        end else begin
            wr.wr_en <= capture | advance;
            if (capture) begin
                for (int c = 0; c < CHOUT; c++) shadow[c] <= ofm[c];
                for (int l = 0; l < LANES; l++) wr.wr_data[l] <= ofm[l];
                group      <= '0;
                wr.wr_addr <= AW'(pc_tgt);
            end else if (advance) begin
                for (int l = 0; l < LANES; l++) wr.wr_data[l] <= nxt_lane[l];
                group      <= ng;
                wr.wr_addr <= AW'(ng) * AW'(NPIX) + AW'(pixel_count);
            end
            if (!layer_en)      pixel_count <= '0;
            else if (finish_px) pixel_count <= pc_inc;
            if (state == DRAIN && layer_en && sample && !last) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fire_expand1_ofm_writer.sv
// Randomised bench: pixel-level model feeds a write scoreboard that a
// negedge monitor drains whenever the writer strobes the RAM port.
module tb_fire_expand1_ofm_writer;
    localparam int WOUT   = 32;
    localparam int CHOUT  = 128;
    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int GROUPS = CHOUT / LANES;
    localparam int NPIX   = WOUT * WOUT;
    localparam int AW     = 14;

    typedef struct packed {
        logic [AW-1:0]          addr;
        logic [LANES*WIDTH-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             layer_en;
    logic             sample;
    logic [WIDTH-1:0] ofm [0:CHOUT-1];
    logic             busy;
    logic             ram_feedback;
    logic             overrun;
    logic [10:0]      pixel_count;

    fire_expand1_ofm_writer_if #(.WIDTH(WIDTH), .LANES(LANES), .AW(AW)) wr ();

    fire_expand1_ofm_writer #(
        .WOUT(WOUT), .CHOUT(CHOUT), .WIDTH(WIDTH), .LANES(LANES)
    ) dut (
        .clk(clk), .rst(rst), .layer_en(layer_en), .sample(sample),
        .ofm(ofm), .wr(wr), .busy(busy), .ram_feedback(ram_feedback),
        .overrun(overrun), .pixel_count(pixel_count)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    bit  chk_en   = 1'b0;
    wr_t exp_q [$];
    int  m_rem    = 0;
    int  m_pix    = 0;
    bit  m_done   = 1'b0;
    bit  m_ovr    = 1'b0;
    int  nwr      = 0;
    int  run      = 0;
    int  maxrun   = 0;
    int  cov [0:GROUPS*NPIX-1];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: state outputs against the model, writes against the queue
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", 32'(wr.wr_en), 32'(m_rem > 0));
            chk("busy", 32'(busy), 32'(m_rem > 0));
            chk("pixel_count", 32'(pixel_count), 32'(m_pix));
            chk("ram_feedback", 32'(ram_feedback), 32'(m_done));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            if (wr.wr_en === 1'b1) begin
                logic [LANES*WIDTH-1:0] got;
                wr_t e;
                nwr++;
                run++;
                if (run > maxrun) maxrun = run;
                cov[wr.wr_addr]++;
                for (int l = 0; l < LANES; l++)
                    got[l*WIDTH +: WIDTH] = wr.wr_data[l];
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got addr=%0d exp none",
                             wr.wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr.wr_addr), 32'(e.addr));
                    if (got !== e.data) begin
                        failures++;
                        $display("FAIL wr_data addr=%0d got=%h exp=%h",
                                 e.addr, got, e.data);
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    // One clock edge: model the pixel-level effect of the current inputs
    task automatic tick(input bit s);
        int r = m_rem;
        int p = m_pix;
        bit d = m_done;
        bit o = m_ovr;
        wr_t e;
        sample = s;
        if (!rst || !layer_en) begin
            if (r > 0) repeat (r - 1) void'(exp_q.pop_back());
            r = 0;
            p = 0;
            d = 1'b0;
            if (!rst) o = 1'b0;
        end else begin
            if (r > 0) begin
                r--;
                if (r == 0) begin
                    p++;
                    if (p == NPIX) d = 1'b1;
                end
            end
            if (s && !d) begin
                if (r == 0) begin
                    for (int g = 0; g < GROUPS; g++) begin
                        e.addr = AW'(g * NPIX + p);
                        for (int l = 0; l < LANES; l++)
                            e.data[l*WIDTH +: WIDTH] = ofm[g*LANES + l];
                        exp_q.push_back(e);
                    end
                    r = GROUPS;
                end else begin
                    o = 1'b1;
                end
            end
        end
        @(posedge clk);
        m_rem  = r;
        m_pix  = p;
        m_done = d;
        m_ovr  = o;
        #1;
        sample = 1'b0;
    endtask

    task automatic rand_ofm();
        for (int c = 0; c < CHOUT; c++) ofm[c] = 16'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1'b0);
        rst = 1'b1;
    endtask

    initial begin
        int base;
        int bad;
        logic [LANES*WIDTH-1:0] got;
        rst      = 1'b0;
        layer_en = 1'b0;
        sample   = 1'b0;
        rand_ofm();
        foreach (cov[i]) cov[i] = 0;
        tick(1'b0);
        tick(1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        for (int l = 0; l < LANES; l++)
            got[l*WIDTH +: WIDTH] = wr.wr_data[l];
        chk("rst_wr_addr", 32'(wr.wr_addr), 32'd0);
        chk("rst_wr_data_zero", 32'(got != '0), 32'd0);
        rst = 1'b1;

        // single pixel with channel-indexed data
        layer_en = 1'b1;
        for (int c = 0; c < CHOUT; c++) ofm[c] = 16'(c + 16'h100);
        base = nwr;
        tick(1'b1);
        repeat (24) tick(1'b0);
        chk("single_writes", 32'(nwr - base), 32'd16);

        // back-to-back capture on the last group
        do_reset();
        layer_en = 1'b1;
        maxrun = 0;
        rand_ofm();
        tick(1'b1);
        repeat (15) tick(1'b0);
        rand_ofm();
        tick(1'b1);
        repeat (24) tick(1'b0);
        chk("b2b_run", 32'(maxrun), 32'd32);

        // overrun: sample while group 4 is on the bus
        do_reset();
        layer_en = 1'b1;
        rand_ofm();
        base = nwr;
        tick(1'b1);
        repeat (4) tick(1'b0);
        rand_ofm();
        tick(1'b1);
        repeat (24) tick(1'b0);
        chk("ovr_writes", 32'(nwr - base), 32'd16);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // random sample spacing, including drops and back-to-back
        for (int i = 0; i < 60; i++) begin
            rand_ofm();
            tick(1'b1);
            repeat ($urandom_range(0, 39)) tick(1'b0);
        end
        repeat (20) tick(1'b0);

        // reset at group 5 of pixel 3
        do_reset();
        layer_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ofm();
            tick(1'b1);
            repeat (20) tick(1'b0);
        end
        rand_ofm();
        tick(1'b1);
        repeat (5) tick(1'b0);
        do_reset();
        base = nwr;
        repeat (8) tick(1'b0);
        chk("post_rst_quiet", 32'(nwr - base), 32'd0);
        rand_ofm();
        tick(1'b1);
        repeat (20) tick(1'b0);

        // full layer at the 33-cycle pixel period
        do_reset();
        layer_en = 1'b1;
        foreach (cov[i]) cov[i] = 0;
        base = nwr;
        for (int i = 0; i < NPIX; i++) begin
            rand_ofm();
            tick(1'b1);
            repeat (32) tick(1'b0);
        end
        chk("layer_writes", 32'(nwr - base), 32'(GROUPS * NPIX));
        bad = 0;
        foreach (cov[i]) if (cov[i] != 1) bad++;
        chk("addr_cover", 32'(bad), 32'd0);
        chk("layer_feedback", 32'(ram_feedback), 32'd1);

        // samples in DONE are ignored, then re-arm
        base = nwr;
        repeat (3) begin
            rand_ofm();
            tick(1'b1);
        end
        chk("done_quiet", 32'(nwr - base), 32'd0);
        layer_en = 1'b0;
        tick(1'b0);
        layer_en = 1'b1;
        tick(1'b0);
        rand_ofm();
        tick(1'b1);
        repeat (20) tick(1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fire_expand1_ofm_writer.md
Name: fire_expand1_ofm_writer

Overview:
- Downstream stage of the fire4/fire5 expand-1x1 convolution core.
- On each sample pulse it captures the core's CHOUT parallel 16-bit output feature-map words into a shadow register, then drains them into a LANES-wide banked feature-map RAM, LANES words per cycle.
- Generates the RAM addresses.
- Raises ram_feedback once all WOUT*WOUT pixels of the layer are written; this is the feedback the conv core and the layer controller wait on.

Parameters:
- WOUT, 32, output feature-map width/height; pixels per layer = WOUT*WOUT.
- CHOUT, 128, channels delivered per sample pulse.
- WIDTH, 16, bits per feature-map word.
- LANES, 8, RAM banks written per cycle. CHOUT must be a multiple of LANES.
- GROUPS, CHOUT/LANES (16), derived; write cycles per pixel.
- AW, $clog2(GROUPS*WOUT*WOUT) (14), derived; RAM address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- layer_en  in  1  layer active; low forces IDLE.
- sample  in  1  one-cycle pulse; ofm is valid in this cycle.
- ofm  in  WIDTH x CHOUT (unpacked [0:CHOUT-1])  channel outputs of conv core.
- wr_en  out  1  RAM write strobe, common to all lanes.
- wr_addr  out  AW  RAM address, common to all lanes.
- wr_data  out  WIDTH x LANES (unpacked [0:LANES-1])  lane l data.
- busy  out  1  high in DRAIN.
- ram_feedback  out  1  layer fully written.
- overrun  out  1  sticky; a sample was dropped.
- pixel_count  out  $clog2(WOUT*WOUT)+1  pixels fully written this layer.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; all outputs 0, including wr_data; shadow register, group counter and pixel counter cleared. Reset takes priority over every other event, including mid-drain; no further writes occur after it.
- States:
  - IDLE: waiting for a sample.
  - DRAIN: writing groups of the current pixel.
  - DONE: layer complete.
- IDLE:
  - sample=1 and layer_en=1 → capture ofm into shadow, group=0, go to DRAIN.
  - sample while layer_en=0 → ignored.
- DRAIN, one write per cycle:
  - wr_en=1.
  - wr_data[l] = shadow[group*LANES+l].
  - wr_addr = group*WOUT*WOUT + pixel_count.
  - Layout is channel-group-major: bank l holds channels l, l+LANES, …
  - group increments each cycle.
  - At group=GROUPS-1: pixel_count increments at that edge.
    - If the new pixel_count == WOUT*WOUT → DONE.
    - Else if sample=1 in this same cycle → recapture, group=0, stay in DRAIN (back-to-back, no bubble, no overrun).
    - Else → IDLE.
- Latency: sample at edge t → first wr_en at cycle t+1 → last write at t+GROUPS. busy follows the same window.
- Sample in DRAIN while group != GROUPS-1 → dropped; shadow unchanged; overrun set (sticky until reset). The conv core's pixel period (CHIN+1 = 33 cycles) exceeds GROUPS, so this is an error indicator only.
- DONE:
  - ram_feedback=1; wr_en=0; samples ignored (no overrun).
  - Leaves DONE only on layer_en=0 → IDLE, with pixel_count and ram_feedback cleared. This re-arms the block for the next layer (fire4 → fire5).
- layer_en=0 in DRAIN → next state IDLE. The write in the cycle layer_en is low is suppressed (wr_en=0), and pixel_count is cleared. Partial pixels are not completed.
- wr_en, wr_addr and wr_data are registered outputs and change together. When wr_en=0, wr_addr and wr_data hold their last values.
- No arithmetic on data: pass-through of WIDTH bits. Address arithmetic is unsigned AW bits and never wraps within a layer. Maximum address = GROUPS*WOUT*WOUT-1 = 16383.
- overrun is not cleared by layer_en; only rst clears it.

Test Plan:
- Reset mid-drain:
  - Stimulus: rst=0 asserted at group 5 of pixel 3.
  - Response: next cycle wr_en=0, busy=0, pixel_count=0, ram_feedback=0. No writes until the next sample after rst=1.
- Single pixel, channel-indexed data:
  - Stimulus: layer_en=1; one sample with ofm[c]=c+16'h100.
  - Response: wr_en high exactly cycles t+1..t+16. Cycle k has wr_addr=(k-1)*1024 and wr_data[l]=16'h100+(k-1)*8+l. pixel_count=1, then IDLE.
- Full layer at the 33-cycle period:
  - Stimulus: 1024 samples at a 33-cycle period.
  - Response: exactly 16384 writes with every address 0..16383 written once. ram_feedback rises the cycle after the final write. overrun=0.
- Back-to-back capture:
  - Stimulus: a second sample coincident with group 15 of the previous pixel.
  - Response: wr_en stays high continuously for 32 cycles. Second pixel addresses are g*1024+1. overrun=0.
- Overrun:
  - Stimulus: a sample at group 4.
  - Response: overrun=1 (sticky). The current pixel's remaining data is unchanged, and exactly 16 writes occur for that pixel.
- DONE and re-arm:
  - Stimulus: samples in DONE, then layer_en low for 1 cycle, then a sample.
  - Response: no writes in DONE. ram_feedback and pixel_count return to 0. The new pixel is written at addresses g*1024+0.
